// File: rtl/udp_tx_arb.sv
// udp_tx_arb: round-robin owner of the single eth UDP transmit channel,
// shared by two frame sources in the gmii_tx_clk domain.
// Optional watchdog: define UDP_ARB_TIMEOUT_EN to abort a frame whose
// tx_rdy handshake stalls for WAIT_CYCLES cycles (pulses err and chN_done).
module udp_tx_arb #(
    parameter int WAIT_CYCLES = 1024
) (
    input  logic        gmii_tx_clk,
    input  logic        rst,
    input  logic        ch0_req,
    input  logic        ch1_req,
    input  logic [15:0] ch0_len,
    input  logic [15:0] ch1_len,
    output logic        ch0_grant,
    output logic        ch1_grant,
    output logic        ch0_rd,
    output logic        ch1_rd,
    input  logic [7:0]  ch0_data,
    input  logic [7:0]  ch1_data,
    output logic        ch0_done,
    output logic        ch1_done,
    output logic        udp_tx_en,
    output logic [15:0] udp_tx_data_num,
    input  logic        udp_tx_req,
    output logic [7:0]  udp_tx_data,
    input  logic        tx_rdy,
    output logic        busy,
    output logic        err
);

`ifdef UDP_ARB_TIMEOUT_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif
    localparam logic [15:0] WD_LAST = 16'(WAIT_CYCLES - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_WAIT_BUSY = 3'd2;
    localparam logic [2:0] S_SEND      = 3'd3;
    localparam logic [2:0] S_WAIT_RDY  = 3'd4;

    logic [2:0]  state, state_nxt;
    logic        owner;      // 0 = ch0, 1 = ch1; held through WAIT_RDY
    logic        last;       // previous winner, loses the next tie
    logic        zero_len;   // current grant carried no payload
    logic        drop_q;     // previous cycle had a request we did not forward
    logic [15:0] byte_cnt;
    logic [15:0] wd_cnt;
    logic [1:0]  grant_q, done_q, rd_q;
    logic        en_q, err_q;

    logic        win_vld, win_ch;
    logic [15:0] win_len;
    logic        fwd, wd_hit, done_set;

    // Arbitration: a lone request wins, a tie goes to whoever was not last
    always_comb begin
        win_vld = ch0_req | ch1_req;
        win_ch  = (ch0_req & ch1_req) ? ~last : ch1_req;
        win_len = win_ch ? ch1_len : ch0_len;
    end

    // Forwarding and release conditions
    always_comb begin
        fwd      = ((state == S_WAIT_BUSY) || (state == S_SEND)) && udp_tx_req &&
                   (byte_cnt < udp_tx_data_num);
        wd_hit   = WD_EN && (state != S_IDLE) && (wd_cnt == WD_LAST);
        // A normal frame shows done during WAIT_RDY; an empty frame shows it
        // on the cycle after its grant (i.e. as WAIT_RDY is left).
        done_set = ((state == S_SEND) && tx_rdy) ||
                   ((state == S_WAIT_RDY) && zero_len) ||
                   (wd_hit && (state != S_WAIT_RDY));
    end

    // Next-state logic; a watchdog expiry always returns to IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (win_vld) state_nxt = (win_len == 16'd0) ? S_WAIT_RDY : S_START;
            S_START:     if (tx_rdy)  state_nxt = S_WAIT_BUSY;
            S_WAIT_BUSY: if (!tx_rdy) state_nxt = S_SEND;
            S_SEND:      if (tx_rdy)  state_nxt = S_WAIT_RDY;
            S_WAIT_RDY:               state_nxt = S_IDLE;
            default:                  state_nxt = S_IDLE;
        endcase
        if (wd_hit) state_nxt = S_IDLE;
    end

    // Main sequencer: ownership, registered pulses and byte counting
    always_ff @(posedge gmii_tx_clk) begin
        if (rst) begin
            state           <= S_IDLE;
            owner           <= 1'b0;
            last            <= 1'b1;
            zero_len        <= 1'b0;
            drop_q          <= 1'b0;
            byte_cnt        <= 16'd0;
            udp_tx_data_num <= 16'd0;
            grant_q         <= 2'b00;
            done_q          <= 2'b00;
            rd_q            <= 2'b00;
            en_q            <= 1'b0;
            err_q           <= 1'b0;
        end else begin
            state   <= state_nxt;
            grant_q <= 2'b00;
            done_q  <= 2'b00;
            rd_q    <= 2'b00;
            en_q    <= 1'b0;
            err_q   <= wd_hit;
            drop_q  <= udp_tx_req && !fwd;
            if ((state == S_IDLE) && win_vld) begin
                owner            <= win_ch;
                last             <= win_ch;
                udp_tx_data_num  <= win_len;
                zero_len         <= (win_len == 16'd0);
                grant_q[win_ch]  <= 1'b1;
            end
            if ((state == S_START) && tx_rdy && !wd_hit) begin
                en_q     <= 1'b1;
                byte_cnt <= 16'd0;
            end
            if (fwd) begin
                rd_q[owner] <= 1'b1;
                byte_cnt    <= byte_cnt + 16'd1;
            end
            if (done_set) done_q[owner] <= 1'b1;
        end
    end

    // Watchdog: counts cycles in the current non-IDLE state, restarts on any change
    always_ff @(posedge gmii_tx_clk) begin
        if (rst || !WD_EN || (state == S_IDLE) || (state_nxt != state))
            wd_cnt <= 16'd0;
        else
            wd_cnt <= wd_cnt + 16'd1;
    end

    assign ch0_grant   = grant_q[0];
    assign ch1_grant   = grant_q[1];
    assign ch0_done    = done_q[0];
    assign ch1_done    = done_q[1];
    assign ch0_rd      = rd_q[0];
    assign ch1_rd      = rd_q[1];
    assign udp_tx_en   = en_q;
    assign err         = err_q;
    assign busy        = (state != S_IDLE);
    // Owner's byte goes straight through; padding bytes beyond the length are 0
    assign udp_tx_data = ((state == S_IDLE) || drop_q) ? 8'h00 :
                         (owner ? ch1_data : ch0_data);

endmodule

// File: tb/tb_udp_tx_arb.sv
// tb_udp_tx_arb: directed plus randomized frames against a simple eth model
// and a frame-level reference (winner order, byte pattern, forwarded counts).
module tb_udp_tx_arb;
    logic        gmii_tx_clk = 1'b0;
    logic        rst = 1'b1;
    logic        ch0_req = 1'b0, ch1_req = 1'b0;
    logic [15:0] ch0_len = 16'd0, ch1_len = 16'd0;
    logic        ch0_grant, ch1_grant, ch0_rd, ch1_rd, ch0_done, ch1_done;
    logic [7:0]  ch0_data, ch1_data;
    logic        udp_tx_en;
    logic [15:0] udp_tx_data_num;
    logic        udp_tx_req = 1'b0;
    logic [7:0]  udp_tx_data;
    logic        tx_rdy = 1'b1;
    logic        busy, err;

    int n_asrt = 0;
    int n_fail = 0;

    int rdidx0 = 0, rdidx1 = 0;
    int rd0_tot = 0, rd1_tot = 0, g0_tot = 0, g1_tot = 0;
    int d0_tot = 0, d1_tot = 0, en_tot = 0;

    udp_tx_arb #(.WAIT_CYCLES(64)) dut (
        .gmii_tx_clk(gmii_tx_clk), .rst(rst),
        .ch0_req(ch0_req), .ch1_req(ch1_req),
        .ch0_len(ch0_len), .ch1_len(ch1_len),
        .ch0_grant(ch0_grant), .ch1_grant(ch1_grant),
        .ch0_rd(ch0_rd), .ch1_rd(ch1_rd),
        .ch0_data(ch0_data), .ch1_data(ch1_data),
        .ch0_done(ch0_done), .ch1_done(ch1_done),
        .udp_tx_en(udp_tx_en), .udp_tx_data_num(udp_tx_data_num),
        .udp_tx_req(udp_tx_req), .udp_tx_data(udp_tx_data),
        .tx_rdy(tx_rdy), .busy(busy), .err(err)
    );

    always #5 gmii_tx_clk = ~gmii_tx_clk;

    // Payload byte k of a frame from channel ch; never 0x00
    function automatic logic [7:0] pat(input int ch, input int k);
        return 8'((ch != 0 ? 128 : 16) + k);
    endfunction

    // Sources present their next byte while their rd is high, junk otherwise
    assign ch0_data = ch0_rd ? pat(0, rdidx0) : 8'hEE;
    assign ch1_data = ch1_rd ? pat(1, rdidx1) : 8'hEE;

    // Event counters sampled mid-cycle
    always @(negedge gmii_tx_clk) begin
        if (ch0_grant) rdidx0 <= 0; else if (ch0_rd) rdidx0 <= rdidx0 + 1;
        if (ch1_grant) rdidx1 <= 0; else if (ch1_rd) rdidx1 <= rdidx1 + 1;
        rd0_tot <= rd0_tot + int'(ch0_rd);
        rd1_tot <= rd1_tot + int'(ch1_rd);
        g0_tot  <= g0_tot + int'(ch0_grant);
        g1_tot  <= g1_tot + int'(ch1_grant);
        d0_tot  <= d0_tot + int'(ch0_done);
        d1_tot  <= d1_tot + int'(ch1_done);
        en_tot  <= en_tot + int'(udp_tx_en);
    end

    task automatic step();
        @(posedge gmii_tx_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // eth model: start on udp_tx_en, go busy, request nreq bytes, go idle
    task automatic eth_frame(input int ch, input int len, input int nreq,
                             input int raise, input string tag);
        int t;
        t = 0;
        while (!udp_tx_en && t < 20) begin step(); t++; end
        chk({tag, "_en_delay"}, t, 1);
        chk({tag, "_num"}, udp_tx_data_num, len);
        if (raise == 0) ch0_req = 1'b1;
        if (raise == 1) ch1_req = 1'b1;
        tx_rdy = 1'b0;
        step();
        for (int i = 0; i < nreq; i++) begin
            udp_tx_req = 1'b1;
            step();
            chk({tag, "_byte"}, udp_tx_data, (i < len) ? pat(ch, i) : 8'h00);
        end
        udp_tx_req = 1'b0;
        tx_rdy = 1'b1;
        step();
    endtask

    // One complete frame: grant, eth transfer, done; checks the frame-level results
    task automatic serve(input int ch, input int len, input int nreq,
                         input int raise, input string tag);
        int t, rs0, rs1, ds0, ds1, exp_rd;
        t = 0;
        while (!(ch0_grant || ch1_grant) && t < 20) begin step(); t++; end
        chk({tag, "_grant_delay"}, t, 1);
        chk({tag, "_grant"}, {ch1_grant, ch0_grant}, (ch != 0) ? 2'b10 : 2'b01);
        if (ch != 0) ch1_req = 1'b0; else ch0_req = 1'b0;
        rs0 = rd0_tot; rs1 = rd1_tot; ds0 = d0_tot; ds1 = d1_tot;
        eth_frame(ch, len, nreq, raise, tag);
        chk({tag, "_done"}, {ch1_done, ch0_done}, (ch != 0) ? 2'b10 : 2'b01);
        exp_rd = (nreq < len) ? nreq : len;
        chk({tag, "_rd_own"}, (ch != 0) ? rd1_tot - rs1 : rd0_tot - rs0, exp_rd);
        chk({tag, "_rd_other"}, (ch != 0) ? rd0_tot - rs0 : rd1_tot - rs1, 0);
        step();
        chk({tag, "_done_once"}, (ch != 0) ? d1_tot - ds1 : d0_tot - ds0, 1);
        chk({tag, "_idle"}, {busy, ch1_done, ch0_done}, 3'b000);
    endtask

    initial begin
        int g0s, es, ds1, mode, first, second, l0, l1, lf, ls;
        logic last_m;

        // Reset state
        repeat (3) step();
        chk("reset_ctrl", {ch1_grant, ch0_grant, ch1_done, ch0_done, ch1_rd, ch0_rd,
                           udp_tx_en, busy, err}, 9'd0);
        chk("reset_num", udp_tx_data_num, 16'd0);
        chk("reset_data", udp_tx_data, 8'h00);
        rst = 1'b0;
        step();

        // Single ch0 frame of 18 bytes
        ch0_len = 16'd18; ch0_req = 1'b1;
        serve(0, 18, 18, -1, "t1");

        // Reset while ch1 is mid-frame
        ch1_len = 16'd8; ch1_req = 1'b1;
        step();
        chk("rst_grant", ch1_grant, 1'b1);
        ch1_req = 1'b0;
        step();
        chk("rst_en", udp_tx_en, 1'b1);
        tx_rdy = 1'b0; step();
        udp_tx_req = 1'b1; repeat (3) step();
        ds1 = d1_tot;
        rst = 1'b1; udp_tx_req = 1'b0;
        step();
        chk("rst_ctrl", {ch1_grant, ch0_grant, ch1_done, ch0_done, ch1_rd, ch0_rd,
                         udp_tx_en, busy, err}, 9'd0);
        chk("rst_num", udp_tx_data_num, 16'd0);
        chk("rst_data", udp_tx_data, 8'h00);
        rst = 1'b0; tx_rdy = 1'b1;
        repeat (3) step();
        chk("rst_no_done", d1_tot - ds1, 0);

        // Tie after reset goes to ch0; ch0 re-requests while ch1 sends 25 bytes of 20
        ch0_len = 16'd10; ch1_len = 16'd20;
        ch0_req = 1'b1; ch1_req = 1'b1;
        serve(0, 10, 10, -1, "t2a");
        ch0_len = 16'd5;
        g0s = g0_tot;
        serve(1, 20, 25, 0, "t2b");
        chk("t2_ch0_waits", g0_tot - g0s, 0);
        serve(0, 5, 5, -1, "t2c");

        // Empty frame: grant then done, no start pulse
        ch1_len = 16'd0; ch1_req = 1'b1;
        es = en_tot;
        step();
        chk("zl_grant", {ch1_grant, ch0_grant}, 2'b10);
        ch1_req = 1'b0;
        step();
        chk("zl_done", {ch1_done, ch0_done, ch1_grant}, 3'b100);
        repeat (3) step();
        chk("zl_no_en", en_tot - es, 0);
        chk("zl_idle", busy, 1'b0);

        // Random frames against the round-robin reference
        last_m = 1'b1;
        for (int r = 0; r < 12; r++) begin
            mode = $urandom_range(0, 2);
            l0 = $urandom_range(1, 12);
            l1 = $urandom_range(1, 12);
            ch0_len = 16'(l0); ch1_len = 16'(l1);
            ch0_req = (mode != 1); ch1_req = (mode != 0);
            first = (mode == 2) ? (last_m ? 0 : 1) : ((mode == 1) ? 1 : 0);
            lf = (first != 0) ? l1 : l0;
            serve(first, lf, lf + $urandom_range(0, 3), -1, "rnd_a");
            last_m = (first != 0);
            if (mode == 2) begin
                second = 1 - first;
                ls = (second != 0) ? l1 : l0;
                serve(second, ls, ls + $urandom_range(0, 3), -1, "rnd_b");
                last_m = (second != 0);
            end
        end

`ifdef UDP_ARB_TIMEOUT_EN
        // Watchdog: eth never goes idle, frame aborted 64 cycles after grant
        tx_rdy = 1'b0; ch0_len = 16'd5; ch0_req = 1'b1;
        es = en_tot;
        step();
        chk("wd_grant", ch0_grant, 1'b1);
        ch0_req = 1'b0;
        repeat (63) step();
        chk("wd_early", {err, ch0_done, busy}, 3'b001);
        step();
        chk("wd_hit", {err, ch0_done, busy}, 3'b110);
        step();
        chk("wd_after", {err, ch0_done, busy}, 3'b000);
        chk("wd_no_en", en_tot - es, 0);
        tx_rdy = 1'b1;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
